// File: rtl/digit_pkg.sv
// -----------------------------------------------------------------------------
// digit_pkg
// Shared constants and helpers for the digit register bank and its scan
// divider.
//   DIGIT_W_DEF    - default bits per digit
//   NUM_DIGITS_DEF - default number of stored digits
//   SCAN_DIV_DEF   - default dwell (clock cycles) per scanned digit
//   idx_w()        - width of an index able to address n items (never 0)
// -----------------------------------------------------------------------------
package digit_pkg;

  localparam int DIGIT_W_DEF    = 4;
  localparam int NUM_DIGITS_DEF = 4;
  localparam int SCAN_DIV_DEF   = 50000;

  // $clog2(1) is 0, which would give a zero-width vector, so clamp to 1 bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/digit_scan_bank_scan_divider.sv
// -----------------------------------------------------------------------------
// scan_divider
// Modulo-SCAN_DIV free-running counter. div_cnt runs 0..SCAN_DIV-1 and wraps;
// the terminal count is presented as a one-cycle advance pulse.
// Ports:
//   clk     - system clock, rising edge
//   reset   - synchronous, active-high; returns div_cnt to 0
//   advance - high during the cycle in which div_cnt == SCAN_DIV-1
// -----------------------------------------------------------------------------
module scan_divider
  import digit_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic advance
);

  localparam int               CNT_W = idx_w(SCAN_DIV);
  localparam logic [CNT_W-1:0] TERM  = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] div_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_reg <= '0;
    end else if (div_cnt_reg == TERM) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  // With SCAN_DIV=1 TERM is 0, so advance stays high and the index moves
  // every cycle.
  assign advance = (div_cnt_reg == TERM);

endmodule

// File: rtl/digit_scan_bank.sv
// -----------------------------------------------------------------------------
// digit_scan_bank
// Digit register bank with a parallel view and a time-multiplexed scan view
// feeding a shared seven-segment decoder.
// Ports:
//   clk         - system clock, rising edge
//   reset       - synchronous, active-high; highest priority
//   wr_en       - single-cycle write strobe
//   wr_addr     - digit index to write (out-of-range indices are ignored)
//   wr_data     - value to store
//   clear       - synchronous zero of all digits, wins over a same-cycle write
//   digits_flat - all digits, digit k at [k*DIGIT_W +: DIGIT_W]
//   scan_sel    - one-hot select of the scanned digit (registered)
//   scan_data   - value of the scanned digit (registered)
//   scan_blank  - scanned digit is a suppressed leading zero (registered)
//   frame_tick  - one-cycle pulse in the cycle scan_idx wraps back to 0
// Build option:
//   BLANK_LEADING_ZEROS_EN - when defined, leading zeros above digit 0 are
//   blanked; otherwise scan_blank is tied to 0 and no blanking logic exists.
// -----------------------------------------------------------------------------
module digit_scan_bank
  import digit_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int DIGIT_W    = DIGIT_W_DEF,
  parameter int SCAN_DIV   = SCAN_DIV_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [idx_w(NUM_DIGITS)-1:0]  wr_addr,
  input  logic [DIGIT_W-1:0]            wr_data,
  input  logic                          clear,
  output logic [NUM_DIGITS*DIGIT_W-1:0] digits_flat,
  output logic [NUM_DIGITS-1:0]         scan_sel,
  output logic [DIGIT_W-1:0]            scan_data,
  output logic                          scan_blank,
  output logic                          frame_tick
);

  localparam int               IDX_W    = idx_w(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [DIGIT_W-1:0]    digit_arr [NUM_DIGITS];
  logic                  advance;
  logic [IDX_W-1:0]      scan_idx_reg;
  logic [NUM_DIGITS-1:0] scan_sel_reg;
  logic [DIGIT_W-1:0]    scan_data_reg;
  logic                  frame_tick_reg;

  // ---------------------------------------------------------------------------
  // Storage: one register per digit. An address that matches no generated
  // index (wr_addr >= NUM_DIGITS) simply writes nothing.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [DIGIT_W-1:0] digit_reg;

      always_ff @(posedge clk) begin
        if (reset || clear) begin
          digit_reg <= '0;
        end else if (wr_en && (wr_addr == IDX_W'(gi))) begin
          digit_reg <= wr_data;
        end
      end

      assign digit_arr[gi]                       = digit_reg;
      assign digits_flat[gi*DIGIT_W +: DIGIT_W]  = digit_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Scan timing
  // ---------------------------------------------------------------------------
  scan_divider #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_divider (
    .clk     (clk),
    .reset   (reset),
    .advance (advance)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_idx_reg <= '0;
    end else if (advance) begin
      scan_idx_reg <= (scan_idx_reg == LAST_IDX) ? '0 : scan_idx_reg + 1'b1;
    end
  end

  // Outputs are sampled from the current index and storage, so scan_sel and
  // scan_data trail scan_idx by one cycle and a write reaches scan_data two
  // cycles after its strobe. frame_tick is aligned with scan_idx itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_sel_reg   <= NUM_DIGITS'(1);
      scan_data_reg  <= '0;
      frame_tick_reg <= 1'b0;
    end else begin
      scan_sel_reg   <= NUM_DIGITS'(1) << scan_idx_reg;
      scan_data_reg  <= digit_arr[scan_idx_reg];
      frame_tick_reg <= advance && (scan_idx_reg == LAST_IDX);
    end
  end

  assign scan_sel   = scan_sel_reg;
  assign scan_data  = scan_data_reg;
  assign frame_tick = frame_tick_reg;

  // ---------------------------------------------------------------------------
  // Leading-zero blanking
  // ---------------------------------------------------------------------------
`ifdef BLANK_LEADING_ZEROS_EN
  // zero_vec[k]: digit k is zero (digit 0 never blanks, so it is not needed).
  // Digit k blanks when it and every digit above it are zero.
  logic [NUM_DIGITS-1:1] zero_vec;
  logic [NUM_DIGITS-1:0] blank_vec;
  logic                  scan_blank_reg;

  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
      if (gi == 0) begin : g_lsd
        assign blank_vec[gi] = 1'b0;
      end else begin : g_upper
        assign zero_vec[gi]  = (digit_arr[gi] == '0);
        assign blank_vec[gi] = &zero_vec[NUM_DIGITS-1:gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_blank_reg <= 1'b0;
    end else begin
      scan_blank_reg <= blank_vec[scan_idx_reg];
    end
  end

  assign scan_blank = scan_blank_reg;
`else
  assign scan_blank = 1'b0;
`endif

endmodule

// File: tb/tb_digit_scan_bank.sv
// -----------------------------------------------------------------------------
// tb_digit_scan_bank
// Directed bench for digit_scan_bank (NUM_DIGITS=4, DIGIT_W=4, SCAN_DIV=4).
// Each driven cycle pushes the expected outputs from a behavioural model onto
// a scoreboard queue; after the edge they are popped and compared. Directed
// checks with literal values cover the scenarios of interest on top of that.
// Honours BLANK_LEADING_ZEROS_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_digit_scan_bank;

  localparam int ND = 4;
  localparam int DW = 4;
  localparam int SD = 4;

`ifdef BLANK_LEADING_ZEROS_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [3:0]  wr_data;
  logic        clear;
  logic [15:0] digits_flat;
  logic [3:0]  scan_sel;
  logic [3:0]  scan_data;
  logic        scan_blank;
  logic        frame_tick;

  always #5 clk = ~clk;

  digit_scan_bank #(
    .NUM_DIGITS (ND),
    .DIGIT_W    (DW),
    .SCAN_DIV   (SD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .clear       (clear),
    .digits_flat (digits_flat),
    .scan_sel    (scan_sel),
    .scan_data   (scan_data),
    .scan_blank  (scan_blank),
    .frame_tick  (frame_tick)
  );

  typedef struct packed {
    logic [3:0]  sel;
    logic [3:0]  data;
    logic        blank;
    logic        tick;
    logic [15:0] flat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Behavioural model state
  int m_dig [ND];
  int m_div;
  int m_idx;

  // Observations gathered by collect()
  int         col_data  [ND];
  int         col_blank [ND];
  int         tick_cnt;
  int         sel_changes;
  int         bad_gap;
  logic [3:0] sel_seq[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got=%h want=%h", tag, obs, want);
    end
  endtask

  function automatic logic m_blank(input int idx);
    logic b;
    b = (idx != 0) && (m_dig[idx] == 0);
    for (int k = idx + 1; k < ND; k++) begin
      if (m_dig[k] != 0) b = 1'b0;
    end
    return b & BLANK_EN;
  endfunction

  // Drive one cycle, advance the model at the edge, then compare.
  task automatic cycle(input logic r, input logic c, input logic we,
                       input logic [1:0] a, input logic [3:0] d);
    exp_t e;
    exp_t x;
    reset   = r;
    clear   = c;
    wr_en   = we;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < ND; k++) m_dig[k] = 0;
      m_div   = 0;
      m_idx   = 0;
      e.sel   = 4'b0001;
      e.data  = 4'h0;
      e.blank = 1'b0;
      e.tick  = 1'b0;
    end else begin
      e.sel   = 4'b0001 << m_idx;
      e.data  = 4'(m_dig[m_idx]);
      e.blank = m_blank(m_idx);
      e.tick  = (m_div == SD - 1) && (m_idx == ND - 1);
      if (c) begin
        for (int k = 0; k < ND; k++) m_dig[k] = 0;
      end else if (we) begin
        m_dig[a] = int'(d);
      end
      if (m_div == SD - 1) begin
        m_div = 0;
        m_idx = (m_idx + 1) % ND;
      end else begin
        m_div++;
      end
    end
    e.flat = {4'(m_dig[3]), 4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0])};
    sb.push_back(e);
    #1;
    x = sb.pop_front();
    chk("sb_scan_sel",    16'(scan_sel),   16'(x.sel));
    chk("sb_scan_data",   16'(scan_data),  16'(x.data));
    chk("sb_scan_blank",  16'(scan_blank), 16'(x.blank));
    chk("sb_frame_tick",  16'(frame_tick), 16'(x.tick));
    chk("sb_digits_flat", digits_flat,     x.flat);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] d);
    cycle(1'b0, 1'b0, 1'b1, a, d);
  endtask

  // Idle n cycles, recording per-digit data/blank, frame ticks and the
  // spacing of scan_sel changes.
  task automatic collect(input int n);
    logic [3:0] prev;
    int         last_change;
    int         idx;
    tick_cnt    = 0;
    sel_changes = 0;
    bad_gap     = 0;
    last_change = -1;
    sel_seq.delete();
    prev = scan_sel;
    for (int i = 0; i < n; i++) begin
      idle(1);
      if (frame_tick) tick_cnt++;
      if (scan_sel != prev) begin
        if (last_change >= 0 && (i - last_change) != SD) bad_gap++;
        last_change = i;
        sel_changes++;
        sel_seq.push_back(scan_sel);
        prev = scan_sel;
      end
      idx = -1;
      case (scan_sel)
        4'b0001: idx = 0;
        4'b0010: idx = 1;
        4'b0100: idx = 2;
        4'b1000: idx = 3;
        default: idx = -1;
      endcase
      if (idx >= 0) begin
        col_data[idx]  = int'(scan_data);
        col_blank[idx] = int'(scan_blank);
      end
    end
  endtask

  initial begin
    logic [3:0] want_seq [4];
    int         n;
    want_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset = 1'b1; clear = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 4'd0;
    for (int k = 0; k < ND; k++) m_dig[k] = 0;
    m_div = 0;
    m_idx = 0;

    // Reset values
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
    chk("rst_scan_sel",   16'(scan_sel),   16'h0001);
    chk("rst_scan_data",  16'(scan_data),  16'h0000);
    chk("rst_scan_blank", 16'(scan_blank), 16'h0000);
    chk("rst_frame_tick", 16'(frame_tick), 16'h0000);
    chk("rst_flat",       digits_flat,     16'h0000);

    // Free-running scan after release: four 4-cycle steps, one frame tick
    collect(20);
    chk("scan_changes", 16'(sel_changes), 16'd4);
    chk("scan_gaps",    16'(bad_gap),     16'd0);
    chk("frame_ticks",  16'(tick_cnt),    16'd1);
    for (int i = 0; i < 4; i++) begin
      chk("scan_seq", 16'(sel_seq[i]), 16'(want_seq[i]));
    end

    // Consecutive writes 1,2,3,4 to digits 0..3
    wr(2'd0, 4'h1);
    wr(2'd1, 4'h2);
    wr(2'd2, 4'h3);
    wr(2'd3, 4'h4);
    chk("wr_flat", digits_flat, 16'h4321);
    collect(20);
    for (int i = 0; i < ND; i++) begin
      chk("wr_scan_data", 16'(col_data[i]), 16'(i + 1));
    end

    // clear beats a same-cycle write
    cycle(1'b0, 1'b1, 1'b1, 2'd2, 4'h9);
    chk("clr_flat", digits_flat, 16'h0000);
    idle(1);
    chk("clr_flat_hold", digits_flat, 16'h0000);

    // Write digit 3 while it is being scanned
    for (int g = 0; g < 40 && !(m_idx == 3 && m_div == 0); g++) idle(1);
    wr(2'd3, 4'h7);
    chk("live_flat_hi", 16'(digits_flat[15:12]), 16'h0007);
    chk("live_sel_1",   16'(scan_sel),           16'h0008);
    chk("live_data_1",  16'(scan_data),          16'h0000);
    idle(1);
    chk("live_data_2",  16'(scan_data),          16'h0007);
    chk("live_sel_2",   16'(scan_sel),           16'h0008);

    // Reset in the middle of digit 2's dwell
    wr(2'd0, 4'h1);
    wr(2'd1, 4'h2);
    for (int g = 0; g < 40 && !(m_idx == 2 && m_div == 1); g++) idle(1);
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
    chk("mid_rst_sel",  16'(scan_sel),  16'h0001);
    chk("mid_rst_flat", digits_flat,    16'h0000);
    chk("mid_rst_data", 16'(scan_data), 16'h0000);
    // The advance fires 4 cycles after reset; scan_sel shows it one later.
    n = 0;
    do begin
      idle(1);
      n++;
    end while (scan_sel == 4'b0001 && n < 20);
    chk("mid_rst_next_sel", 16'(n), 16'd5);

    // Leading-zero blanking with digits 3..0 = 0,0,3,0
    cycle(1'b0, 1'b1, 1'b0, 2'd0, 4'd0);
    wr(2'd1, 4'h3);
    collect(20);
    chk("blank_d1_data", 16'(col_data[1]), 16'h0003);
    for (int i = 0; i < ND; i++) begin
      chk("blank_seq_a", 16'(col_blank[i]), 16'(BLANK_EN && i >= 2));
    end
    wr(2'd3, 4'h5);
    collect(20);
    for (int i = 0; i < ND; i++) begin
      chk("blank_seq_b", 16'(col_blank[i]), 16'h0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
